// File: rtl/vec_cfg_pkg.sv
// Shared definitions for the vector configuration controller: vtype layout,
// instruction kinds, FSM encoding and the latched request record.
package vec_cfg_pkg;

    localparam int VLMUL_LSB = 0;
    localparam int VSEW_LSB  = 3;
    localparam int VTA_BIT   = 6;
    localparam int VMA_BIT   = 7;
    localparam int VILL_BIT  = 31;

    localparam logic [31:0] VILL_VTYPE = 32'h8000_0000;
    localparam logic [2:0]  VLMUL_RSVD = 3'b100;

    typedef enum logic [1:0] {
        KIND_VSETVLI  = 2'd0,
        KIND_VSETIVLI = 2'd1,
        KIND_VSETVL   = 2'd2,
        KIND_RSVD     = 2'd3
    } cfg_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    typedef struct packed {
        cfg_kind_e   kind;
        logic [4:0]  rs1_idx;
        logic [4:0]  rd_idx;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [10:0] zimm;
        logic [4:0]  uimm;
    } cfg_req_t;

endpackage

// File: rtl/vec_cfg_controller_vlmax_calc.sv
// VLMAX and SEW/LMUL legality for one candidate vtype; purely combinational.
module vlmax_calc
    import vec_cfg_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int ELEN = 32
) (
    input  logic [2:0]  vsew,
    input  logic [2:0]  vlmul,
    output logic [31:0] vlmax,
    output logic        illegal
);

    logic [31:0] sew;
    logic [31:0] base;
    logic [3:0]  frac_sh;

    always_comb begin
        sew     = 32'd8 << vsew;
        base    = 32'(VLEN) >> (32'd3 + 32'(vsew));
        frac_sh = 4'd8 - {1'b0, vlmul};
        vlmax   = base;
        illegal = (sew > 32'(ELEN));
        if (vlmul == VLMUL_RSVD) begin
            illegal = 1'b1;
        end else if (vlmul[2]) begin
            // fractional LMUL: SEW must fit in ELEN*LMUL
            vlmax = base >> frac_sh;
            if (sew > (32'(ELEN) >> frac_sh)) illegal = 1'b1;
        end else begin
            vlmax = base << vlmul;
        end
    end

endmodule

// File: rtl/vec_cfg_controller.sv
// Sequences vsetvli/vsetivli/vsetvl: latch, compute vtype/VLMAX/AVL, then
// commit vl/vtype and write the new vl back to the scalar register file.
module vec_cfg_controller
    import vec_cfg_pkg::*;
#(
    parameter int VLEN = 128,
    parameter int ELEN = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_kind,
    input  logic [4:0]  rs1_idx,
    input  logic [4:0]  rd_idx,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [10:0] zimm,
    input  logic [4:0]  uimm,
    input  logic        flush,
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic [31:0] vl,
    output logic [31:0] vtype,
    output logic        vill,
    output logic        stall
);

    state_e      state_q, state_d;
    cfg_req_t    req_q, req_d;
    logic [31:0] vtype_new_q, vtype_new_d;
    logic [31:0] vlmax_q, vlmax_d;
    logic [31:0] avl_q, avl_d;
    logic [31:0] vl_q, vl_d;
    logic [31:0] vtype_q, vtype_d;
    logic        rd_we_q, rd_we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_wdata_q, rd_wdata_d;

    logic [31:0] cand_vtype, cand_avl, calc_vlmax, commit_vl;
    logic        calc_ill, cand_ill;

    vlmax_calc #(.VLEN(VLEN), .ELEN(ELEN)) u_vlmax (
        .vsew    (cand_vtype[VSEW_LSB +: 3]),
        .vlmul   (cand_vtype[VLMUL_LSB +: 3]),
        .vlmax   (calc_vlmax),
        .illegal (calc_ill)
    );

    always_comb begin
        cand_vtype = req_q.rs2_data;
        case (req_q.kind)
            KIND_VSETVLI:  cand_vtype = {21'd0, req_q.zimm};
            KIND_VSETIVLI: cand_vtype = {22'd0, req_q.zimm[9:0]};
            default:       cand_vtype = req_q.rs2_data;
        endcase
        cand_ill = calc_ill || cand_vtype[VILL_BIT] || (|cand_vtype[VILL_BIT-1:VMA_BIT+1])
                   || (req_q.kind == KIND_RSVD);
        // rs1=x0 selects VLMAX when writing a real rd, otherwise keeps the current vl
        if (req_q.kind == KIND_VSETIVLI) cand_avl = {27'd0, req_q.uimm};
        else if (req_q.rs1_idx != 5'd0)  cand_avl = req_q.rs1_data;
        else if (req_q.rd_idx != 5'd0)   cand_avl = '1;
        else                             cand_avl = vl_q;
        commit_vl = (avl_q < vlmax_q) ? avl_q : vlmax_q;
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        vtype_new_d = vtype_new_q;
        vlmax_d     = vlmax_q;
        avl_d       = avl_q;
        vl_d        = vl_q;
        vtype_d     = vtype_q;
        rd_we_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_wdata_d  = rd_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid && !flush) begin
                    req_d = '{kind: cfg_kind_e'(cfg_kind), rs1_idx: rs1_idx, rd_idx: rd_idx,
                              rs1_data: rs1_data, rs2_data: rs2_data, zimm: zimm, uimm: uimm};
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    // an illegal vtype forces VLMAX to 0 so the commit yields vl=0
                    vtype_new_d = cand_ill ? VILL_VTYPE : cand_vtype;
                    vlmax_d     = cand_ill ? 32'd0 : calc_vlmax;
                    avl_d       = cand_avl;
                    state_d     = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                vl_d       = commit_vl;
                vtype_d    = vtype_new_q;
                rd_we_d    = 1'b1;
                rd_addr_d  = req_q.rd_idx;
                rd_wdata_d = commit_vl;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            vtype_new_q <= VILL_VTYPE;
            vlmax_q     <= '0;
            avl_q       <= '0;
            vl_q        <= '0;
            vtype_q     <= VILL_VTYPE;
            rd_we_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            vtype_new_q <= vtype_new_d;
            vlmax_q     <= vlmax_d;
            avl_q       <= avl_d;
            vl_q        <= vl_d;
            vtype_q     <= vtype_d;
            rd_we_q     <= rd_we_d;
            rd_addr_q   <= rd_addr_d;
            rd_wdata_q  <= rd_wdata_d;
        end
    end

    assign cfg_ready = (state_q == ST_IDLE);
    assign stall     = (state_q != ST_IDLE);
    assign vl        = vl_q;
    assign vtype     = vtype_q;
    assign vill      = vtype_q[VILL_BIT];
    assign rd_we     = rd_we_q;
    assign rd_addr   = rd_addr_q;
    assign rd_wdata  = rd_wdata_q;

endmodule

// File: tb/tb_vec_cfg_controller.sv
// Directed bench for vec_cfg_controller with a per-cycle compare against an
// arithmetic model of the vector configuration rules.
module tb_vec_cfg_controller;

    localparam int VLEN = 128;
    localparam int ELEN = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_kind = '0;
    logic [4:0]  rs1_idx = '0;
    logic [4:0]  rd_idx = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [10:0] zimm = '0;
    logic [4:0]  uimm = '0;
    logic        flush = 1'b0;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] vl;
    logic [31:0] vtype;
    logic        vill;
    logic        stall;

    int total = 0;
    int bad = 0;

    vec_cfg_controller #(.VLEN(VLEN), .ELEN(ELEN)) dut (
        .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_kind(cfg_kind), .rs1_idx(rs1_idx), .rd_idx(rd_idx), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .zimm(zimm), .uimm(uimm), .flush(flush), .rd_we(rd_we),
        .rd_addr(rd_addr), .rd_wdata(rd_wdata), .vl(vl), .vtype(vtype), .vill(vill),
        .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one configuration instruction, from LMUL/SEW arithmetic.
    function automatic void model_cfg(input logic [1:0] k, input logic [4:0] r1i, input logic [4:0] rdi,
                                      input logic [31:0] r1d, input logic [31:0] r2d,
                                      input logic [10:0] zi, input logic [4:0] ui,
                                      input logic [31:0] old_vl,
                                      output logic [31:0] nvl, output logic [31:0] nvt);
        logic [31:0] vt, avl;
        int sew, lnum, lden, vmax;
        bit ok;
        vt = (k == 2'd2) ? r2d : (k == 2'd1) ? {22'd0, zi[9:0]} : {21'd0, zi};
        sew = 8 * (1 << int'(vt[5:3]));
        if (vt[2]) begin lnum = 1; lden = 1 << (8 - int'(vt[2:0])); end
        else begin lnum = 1 << int'(vt[2:0]); lden = 1; end
        ok = (k != 2'd3) && (vt[31:8] == 24'd0) && (vt[2:0] != 3'd4) && (sew <= ELEN)
             && (sew * lden <= ELEN * lnum);
        vmax = (VLEN * lnum) / (sew * lden);
        if (k == 2'd1) avl = {27'd0, ui};
        else if (r1i != 0) avl = r1d;
        else if (rdi != 0) avl = 32'hFFFF_FFFF;
        else avl = old_vl;
        nvl = !ok ? 32'd0 : (avl < 32'(vmax)) ? avl : 32'(vmax);
        nvt = ok ? vt : 32'h8000_0000;
    endfunction

    // Timeline model: accept, one calc cycle (flushable), then commit.
    int          m_busy = 0;
    logic [31:0] m_vl = 0, m_vtype = 32'h8000_0000, m_rd_wdata = 0;
    logic [4:0]  m_rd_addr = 0;
    logic        m_rd_we = 0;
    logic [1:0]  o_k;
    logic [4:0]  o_r1i, o_rdi, o_ui;
    logic [31:0] o_r1d, o_r2d;
    logic [10:0] o_zi;

    always @(posedge clock or negedge reset) begin
        logic [31:0] nvl, nvt;
        if (!reset) begin
            m_busy = 0; m_vl = 0; m_vtype = 32'h8000_0000;
            m_rd_we = 0; m_rd_addr = 0; m_rd_wdata = 0;
        end else begin
            m_rd_we = 0;
            if (m_busy == 0) begin
                if (cfg_valid && !flush) begin
                    o_k = cfg_kind; o_r1i = rs1_idx; o_rdi = rd_idx; o_r1d = rs1_data;
                    o_r2d = rs2_data; o_zi = zimm; o_ui = uimm;
                    m_busy = 2;
                end
            end else if (m_busy == 2) begin
                m_busy = flush ? 0 : 1;
            end else begin
                model_cfg(o_k, o_r1i, o_rdi, o_r1d, o_r2d, o_zi, o_ui, m_vl, nvl, nvt);
                m_vl = nvl; m_vtype = nvt; m_rd_we = 1; m_rd_addr = o_rdi; m_rd_wdata = nvl;
                m_busy = 0;
            end
        end
    end

    always @(negedge clock) begin
        chk("cmp_cfg_ready", 32'(cfg_ready), 32'(m_busy == 0));
        chk("cmp_stall", 32'(stall), 32'(m_busy != 0));
        chk("cmp_vl", vl, m_vl);
        chk("cmp_vtype", vtype, m_vtype);
        chk("cmp_vill", 32'(vill), 32'(m_vtype[31]));
        chk("cmp_rd_we", 32'(rd_we), 32'(m_rd_we));
        chk("cmp_rd_addr", 32'(rd_addr), 32'(m_rd_addr));
        chk("cmp_rd_wdata", rd_wdata, m_rd_wdata);
    end

    // flush_at: 1 = during the calc cycle, 2 = during the commit cycle
    task automatic issue(input logic [1:0] k, input logic [4:0] r1i, input logic [4:0] rdi,
                         input logic [31:0] r1d, input logic [31:0] r2d, input logic [10:0] zi,
                         input logic [4:0] ui, input int flush_at,
                         output int lat, output int stalls);
        @(negedge clock);
        cfg_kind = k; rs1_idx = r1i; rd_idx = rdi; rs1_data = r1d; rs2_data = r2d;
        zimm = zi; uimm = ui; cfg_valid = 1'b1;
        lat = -1; stalls = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            cfg_valid = 1'b0;
            flush = (i == flush_at);
            if (stall) stalls++;
            if (rd_we) begin lat = i - 1; break; end
        end
        flush = 1'b0;
    endtask

    initial begin
        int lat, st;
        logic [31:0] pvl, pvt;

        // model pinned against hand-computed results
        model_cfg(2'd0, 5'd5, 5'd6, 32'd100, 32'd0, 11'h010, 5'd0, 32'd0, pvl, pvt);
        chk("pin_e32m1_vl", pvl, 32'd4);
        model_cfg(2'd1, 5'd0, 5'd9, 32'd0, 32'd0, 11'h00F, 5'd3, 32'd0, pvl, pvt);
        chk("pin_e16mf2_vl", pvl, 32'd3);
        model_cfg(2'd2, 5'd5, 5'd6, 32'd100, 32'h18, 11'h0, 5'd0, 32'd7, pvl, pvt);
        chk("pin_e64_vtype", pvt, 32'h8000_0000);

        repeat (3) @(negedge clock);
        chk("rst_vl", vl, 32'd0);
        chk("rst_vtype", vtype, 32'h8000_0000);
        chk("rst_vill", 32'(vill), 32'd1);
        chk("rst_rd_we", 32'(rd_we), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_ready", 32'(cfg_ready), 32'd1);
        chk("idle_stall", 32'(stall), 32'd0);

        issue(2'd0, 5'd5, 5'd6, 32'd100, 32'd0, 11'h010, 5'd0, 0, lat, st);
        chk("t2_latency", 32'(lat), 32'd2);
        chk("t2_stall_cycles", 32'(st), 32'd2);
        chk("t2_rd_addr", 32'(rd_addr), 32'd6);
        chk("t2_rd_wdata", rd_wdata, 32'd4);
        chk("t2_vl", vl, 32'd4);
        chk("t2_vtype", vtype, 32'h10);
        chk("t2_vill", 32'(vill), 32'd0);

        issue(2'd0, 5'd5, 5'd8, 32'd100, 32'd0, 11'h003, 5'd0, 0, lat, st);
        chk("t3_e8m8_vl", vl, 32'd100);
        issue(2'd0, 5'd0, 5'd7, 32'd100, 32'd0, 11'h003, 5'd0, 0, lat, st);
        chk("t3_vlmax_vl", vl, 32'd128);
        issue(2'd0, 5'd0, 5'd0, 32'd100, 32'd0, 11'h010, 5'd0, 0, lat, st);
        chk("t3_keep_vl", vl, 32'd4);
        chk("t3_x0_rd_we", 32'(lat), 32'd2);
        chk("t3_x0_addr", 32'(rd_addr), 32'd0);

        issue(2'd1, 5'd0, 5'd9, 32'd0, 32'd0, 11'h00F, 5'd3, 0, lat, st);
        chk("t4_mf2_vl", vl, 32'd3);
        chk("t4_mf2_vill", 32'(vill), 32'd0);
        issue(2'd1, 5'd0, 5'd9, 32'd0, 32'd0, 11'h410, 5'd31, 0, lat, st);
        chk("ivli_zimm10_vtype", vtype, 32'h10);
        issue(2'd1, 5'd0, 5'd9, 32'd0, 32'd0, 11'h006, 5'd31, 0, lat, st);
        chk("e8mf4_vl", vl, 32'd4);
        issue(2'd1, 5'd0, 5'd9, 32'd0, 32'd0, 11'h005, 5'd31, 0, lat, st);
        chk("e8mf8_vill", 32'(vill), 32'd1);

        issue(2'd2, 5'd5, 5'd10, 32'd100, 32'h18, 11'h0, 5'd0, 0, lat, st);
        chk("t5_e64_vtype", vtype, 32'h8000_0000);
        chk("t5_e64_vl", vl, 32'd0);
        chk("t5_e64_wdata", rd_wdata, 32'd0);
        issue(2'd0, 5'd5, 5'd6, 32'd100, 32'd0, 11'h010, 5'd0, 0, lat, st);
        issue(2'd2, 5'd5, 5'd10, 32'd100, 32'h104, 11'h0, 5'd0, 0, lat, st);
        chk("t5_rsvd_vill", 32'(vill), 32'd1);
        chk("t5_rsvd_vl", vl, 32'd0);
        issue(2'd0, 5'd5, 5'd6, 32'd100, 32'd0, 11'h010, 5'd0, 0, lat, st);
        issue(2'd3, 5'd5, 5'd6, 32'd100, 32'd0, 11'h010, 5'd0, 0, lat, st);
        chk("kind3_vill", 32'(vill), 32'd1);

        issue(2'd0, 5'd5, 5'd6, 32'd100, 32'd0, 11'h010, 5'd0, 0, lat, st);
        issue(2'd0, 5'd5, 5'd11, 32'd100, 32'd0, 11'h003, 5'd0, 1, lat, st);
        chk("t6_flush_calc_no_we", 32'(lat), 32'hFFFF_FFFF);
        chk("t6_flush_calc_stall", 32'(st), 32'd1);
        chk("t6_flush_calc_vl", vl, 32'd4);
        chk("t6_flush_calc_vtype", vtype, 32'h10);

        @(negedge clock);
        cfg_kind = 2'd0; rs1_idx = 5'd5; rd_idx = 5'd11; zimm = 11'h003; cfg_valid = 1'b1; flush = 1'b1;
        @(negedge clock);
        cfg_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_stall", 32'(stall), 32'd0);

        issue(2'd0, 5'd5, 5'd11, 32'd100, 32'd0, 11'h003, 5'd0, 2, lat, st);
        chk("t6_flush_commit_lat", 32'(lat), 32'd2);
        chk("t6_flush_commit_vl", vl, 32'd100);
        chk("t6_flush_commit_addr", 32'(rd_addr), 32'd11);

        @(negedge clock);
        cfg_kind = 2'd0; rs1_idx = 5'd5; rd_idx = 5'd12; rs1_data = 32'd2; zimm = 11'h010; cfg_valid = 1'b1;
        @(negedge clock);
        cfg_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t6_arst_vl", vl, 32'd0);
        chk("t6_arst_vtype", vtype, 32'h8000_0000);
        chk("t6_arst_vill", 32'(vill), 32'd1);
        chk("t6_arst_stall", 32'(stall), 32'd0);
        chk("t6_arst_rd_addr", 32'(rd_addr), 32'd0);
        chk("t6_arst_rd_wdata", rd_wdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        issue(2'd0, 5'd0, 5'd0, 32'd0, 32'd0, 11'h010, 5'd0, 0, lat, st);
        chk("post_rst_keep_vl", vl, 32'd0);
        chk("post_rst_vtype", vtype, 32'h10);
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
